// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with occupancy count; a push while full
// is taken only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] level_q, level_d;
    logic wr, rd;
    always_comb begin
        full    = level_q == (AW+1)'(DEPTH);
        empty   = level_q == '0;
        rd      = pop && !empty;
        wr      = push && (!full || rd);
        wptr_d  = wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q + (AW+1)'(wr) - (AW+1)'(rd);
        rdata   = mem[rptr_q];
        level   = level_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q] <= wdata;
    end
endmodule

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs camera bytes into big-endian 32-bit words, queues
// them, and feeds one word per 32-pulse SPI transfer to spi_slave.
module pixel_word_packer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [7:0]    pix_data,
    input  logic          load_data,
    output logic          spi_start,
    output logic [31:0]   data_in,
    output logic [AW:0]   fifo_level,
    output logic          overflow
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam int         WL    = 32;
    logic [1:0]    bidx_q, bidx_d, idx;
    logic [23:0]   hold_q, hold_d;
    logic [1:0]    state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          start_q, start_d, ovf_q, ovf_d;
    logic [WL-1:0] data_q, data_d, head;
    logic          push, pop, full, empty;
    sync_fifo #(.DEPTH(DEPTH), .W(WL)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata({hold_q, pix_data}),
        .rdata(head), .full(full), .empty(empty), .level(fifo_level)
    );
    always_comb begin
        // a frame_start byte lands in slot 0 of the fresh word
        idx    = frame_start ? 2'd0 : bidx_q;
        push   = pix_valid && idx == 2'd3;
        bidx_d = pix_valid ? idx + 2'd1 : idx;
        hold_d = hold_q;
        if (pix_valid && idx == 2'd0) hold_d[23:16] = pix_data;
        if (pix_valid && idx == 2'd1) hold_d[15:8]  = pix_data;
        if (pix_valid && idx == 2'd2) hold_d[7:0]   = pix_data;
        pop     = state_q == IDLE && !empty;
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        data_d  = data_q;
        if (pop) begin
            state_d = START;
            start_d = 1'b1;
            data_d  = head;
        end else if (state_q == START) begin
            state_d = BUSY;
            cnt_d   = '0;
        end else if (state_q == BUSY && load_data) begin
            cnt_d   = cnt_q + 6'd1;
            state_d = cnt_q == 6'd31 ? IDLE : BUSY;
        end
        ovf_d = ovf_q || (push && full && !pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bidx_q  <= '0;
            hold_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            bidx_q  <= bidx_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end
    assign spi_start = start_q;
    assign data_in   = data_q;
    assign overflow  = ovf_q;
endmodule
